// File: rtl/operand_collector_if.sv
// Handshake and register-file bundle of the operand collector.
// master = issue/RF/execute environment, slave = the collector.
interface operand_collector_if #(
  parameter int unsigned WARP_SIZE      = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned WARP_ID_WIDTH  = 5,
  parameter type         OP_T           = logic [3:0]
);
  logic                                       flush;
  logic                                       in_valid;
  logic                                       in_ready;
  logic [WARP_ID_WIDTH-1:0]                   in_warp_id;
  logic [REG_ADDR_WIDTH-1:0]                  in_rs1;
  logic [REG_ADDR_WIDTH-1:0]                  in_rs2;
  logic [REG_ADDR_WIDTH-1:0]                  in_rd;
  logic                                       in_use_imm;
  logic [DATA_WIDTH-1:0]                      in_imm;
  OP_T                                        in_alu_op;
  logic [WARP_SIZE-1:0]                       in_active_mask;
  logic                                       rf_rd_en;
  logic [WARP_ID_WIDTH-1:0]                   rf_rd_warp;
  logic [REG_ADDR_WIDTH-1:0]                  rf_rd_addr;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]       rf_rd_data;
  logic                                       out_valid;
  logic                                       out_ready;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]       out_operand_a;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]       out_operand_b;
  OP_T                                        out_alu_op;
  logic [WARP_SIZE-1:0]                       out_active_mask;
  logic [WARP_ID_WIDTH-1:0]                   out_warp_id;
  logic [REG_ADDR_WIDTH-1:0]                  out_rd;

  modport master (
    output flush, in_valid, in_warp_id, in_rs1, in_rs2, in_rd, in_use_imm,
           in_imm, in_alu_op, in_active_mask, rf_rd_data, out_ready,
    input  in_ready, rf_rd_en, rf_rd_warp, rf_rd_addr, out_valid,
           out_operand_a, out_operand_b, out_alu_op, out_active_mask,
           out_warp_id, out_rd
  );

  modport slave (
    input  flush, in_valid, in_warp_id, in_rs1, in_rs2, in_rd, in_use_imm,
           in_imm, in_alu_op, in_active_mask, rf_rd_data, out_ready,
    output in_ready, rf_rd_en, rf_rd_warp, rf_rd_addr, out_valid,
           out_operand_a, out_operand_b, out_alu_op, out_active_mask,
           out_warp_id, out_rd
  );
endinterface

// File: rtl/operand_collector.sv
// Operand collector: fetches rs1/rs2 for one warp instruction through a
// single-port, 1-cycle-latency register file and hands them to the ALU.
package operand_collector_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;
endpackage

module operand_collector #(
  parameter int unsigned WARP_SIZE      = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned WARP_ID_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_collector_if.slave   bus
);
  import operand_collector_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_DISPATCH
  } state_t;

  state_t                               r_state, w_next;
  logic [WARP_ID_WIDTH-1:0]             r_warp;
  logic [REG_ADDR_WIDTH-1:0]            r_rs1, r_rs2, r_rd;
  logic                                 r_use_imm;
  logic [DATA_WIDTH-1:0]                r_imm;
  alu_op_t                              r_op;
  logic [WARP_SIZE-1:0]                 r_mask;
  logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] r_opa, r_opb;

  logic w_accept, w_cap_a, w_cap_b_rf, w_cap_b_imm, w_rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_cap_a     = 1'b0;
    w_cap_b_rf  = 1'b0;
    w_cap_b_imm = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RD_A;
        end
      end
      S_RD_A: w_next = S_RD_B;
      S_RD_B: begin
        w_cap_a     = 1'b1;
        w_cap_b_imm = r_use_imm;
        w_next      = r_use_imm ? S_DISPATCH : S_CAP_B;
      end
      S_CAP_B: begin
        w_cap_b_rf = 1'b1;
        w_next     = S_DISPATCH;
      end
      S_DISPATCH: if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // flush overrides accept, captures and the dispatch handshake alike
    if (bus.flush) begin
      w_next      = S_IDLE;
      w_accept    = 1'b0;
      w_cap_a     = 1'b0;
      w_cap_b_rf  = 1'b0;
      w_cap_b_imm = 1'b0;
    end
  end

  assign w_rd_en = (r_state == S_RD_A) || ((r_state == S_RD_B) && !r_use_imm);

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_DISPATCH);
  assign bus.rf_rd_en   = w_rd_en;
  assign bus.rf_rd_warp = w_rd_en ? r_warp : '0;
  assign bus.rf_rd_addr = !w_rd_en ? '0 : (r_state == S_RD_A) ? r_rs1 : r_rs2;

  assign bus.out_operand_a   = r_opa;
  assign bus.out_operand_b   = r_opb;
  assign bus.out_alu_op      = r_op;
  assign bus.out_active_mask = r_mask;
  assign bus.out_warp_id     = r_warp;
  assign bus.out_rd          = r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warp    <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_use_imm <= 1'b0;
      r_imm     <= '0;
      r_op      <= ALU_ADD;
      r_mask    <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
    end else begin
      if (w_accept) begin
        r_warp    <= bus.in_warp_id;
        r_rs1     <= bus.in_rs1;
        r_rs2     <= bus.in_rs2;
        r_rd      <= bus.in_rd;
        r_use_imm <= bus.in_use_imm;
        r_imm     <= bus.in_imm;
        r_op      <= alu_op_t'(bus.in_alu_op);
        r_mask    <= bus.in_active_mask;
      end
      // r0 reads are still issued for uniform timing, but their data is discarded
      for (int unsigned i = 0; i < WARP_SIZE; i++) begin
        if (w_cap_a)
          r_opa[i] <= (r_mask[i] && (r_rs1 != '0)) ? bus.rf_rd_data[i] : '0;
        if (w_cap_b_imm)
          r_opb[i] <= r_mask[i] ? r_imm : '0;
        if (w_cap_b_rf)
          r_opb[i] <= (r_mask[i] && (r_rs2 != '0)) ? bus.rf_rd_data[i] : '0;
      end
    end
  end
endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: directed plan steps followed by
// randomized transactions against a lane-level reference model.
module tb_operand_collector;
  import operand_collector_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  operand_collector_if #(
    .WARP_SIZE(W), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
    .WARP_ID_WIDTH(IW), .OP_T(alu_op_t)
  ) bus ();

  operand_collector #(
    .WARP_SIZE(W), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .WARP_ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int edge_count = 0;
  int K = 0;

  always @(posedge clk) edge_count <= edge_count + 1;

  // Register file model: one full warp per read, data one cycle after the strobe.
  logic [DW-1:0] rf_mem [32][32][W];
  always @(posedge clk)
    for (int i = 0; i < W; i++)
      bus.rf_rd_data[i] <= bus.rf_rd_en ? rf_mem[bus.rf_rd_warp][bus.rf_rd_addr][i] : DW'($urandom);

  logic [DW-1:0] exp_a [W];
  logic [DW-1:0] exp_b [W];
  logic [IW-1:0] exp_w;
  logic [AW-1:0] exp_rd;
  alu_op_t       exp_op;
  logic [W-1:0]  exp_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_rf_rd_en"}, bus.rf_rd_en, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_opa_zero"}, (bus.out_operand_a == '0), 1);
    chk({tag, "_opb_zero"}, (bus.out_operand_b == '0), 1);
    chk({tag, "_op"}, bus.out_alu_op, ALU_ADD);
    chk({tag, "_mask"}, bus.out_active_mask, 0);
    chk({tag, "_warp"}, bus.out_warp_id, 0);
    chk({tag, "_rd"}, bus.out_rd, 0);
    chk({tag, "_rf_warp"}, bus.rf_rd_warp, 0);
    chk({tag, "_rf_addr"}, bus.rf_rd_addr, 0);
  endtask

  // Reference: inactive lanes and r0 sources yield zero, immediate is broadcast.
  task automatic set_exp(input logic [4:0] w, rs1, rs2, rd, input logic ui,
                         input logic [31:0] imm, input alu_op_t op, input logic [31:0] mask);
    for (int i = 0; i < W; i++) begin
      exp_a[i] = (mask[i] && rs1 != 0) ? rf_mem[w][rs1][i] : '0;
      if (!mask[i])      exp_b[i] = '0;
      else if (ui)       exp_b[i] = imm;
      else if (rs2 == 0) exp_b[i] = '0;
      else               exp_b[i] = rf_mem[w][rs2][i];
    end
    exp_w = w; exp_rd = rd; exp_op = op; exp_mask = mask;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_warp"}, bus.out_warp_id, exp_w);
    chk({tag, "_rd"}, bus.out_rd, exp_rd);
    chk({tag, "_op"}, bus.out_alu_op, exp_op);
    chk({tag, "_mask"}, bus.out_active_mask, exp_mask);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("%s_a%0d", tag, i), bus.out_operand_a[i], exp_a[i]);
      chk($sformatf("%s_b%0d", tag, i), bus.out_operand_b[i], exp_b[i]);
    end
  endtask

  task automatic drive_req(input logic [4:0] w, rs1, rs2, rd, input logic ui,
                           input logic [31:0] imm, input alu_op_t op, input logic [31:0] mask);
    @(negedge clk);
    chk("req_in_ready", bus.in_ready, 1);
    bus.in_warp_id = w;  bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
    bus.in_use_imm = ui; bus.in_imm = imm; bus.in_alu_op = op;
    bus.in_active_mask = mask; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    K = edge_count;
    bus.in_valid = 1'b0;
    bus.in_rs1 = AW'($urandom); bus.in_rs2 = AW'($urandom);
    bus.in_imm = $urandom;      bus.in_active_mask = $urandom;
    bus.in_use_imm = 1'($urandom);
  endtask

  task automatic run_txn(input string tag, input logic [4:0] w, rs1, rs2, rd, input logic ui,
                         input logic [31:0] imm, input alu_op_t op, input logic [31:0] mask,
                         input int bp);
    int rd_cyc[$];
    logic [4:0] rd_addr[$];
    logic [4:0] rd_warp[$];
    int lat = 0;
    set_exp(w, rs1, rs2, rd, ui, imm, op, mask);
    bus.out_ready = (bp == 0);
    drive_req(w, rs1, rs2, rd, ui, imm, op, mask);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.rf_rd_en) begin
        rd_cyc.push_back(c); rd_addr.push_back(bus.rf_rd_addr); rd_warp.push_back(bus.rf_rd_warp);
      end
      if (bus.out_valid) begin lat = c; break; end
    end
    chk({tag, "_latency"}, lat, ui ? 3 : 4);
    chk({tag, "_rd_pulses"}, rd_cyc.size(), ui ? 1 : 2);
    if (rd_cyc.size() >= 1) begin
      chk({tag, "_rd_a_cyc"}, rd_cyc[0], 1);
      chk({tag, "_rd_a_addr"}, rd_addr[0], rs1);
      chk({tag, "_rd_a_warp"}, rd_warp[0], w);
    end
    if (!ui && rd_cyc.size() >= 2) begin
      chk({tag, "_rd_b_cyc"}, rd_cyc[1], 2);
      chk({tag, "_rd_b_addr"}, rd_addr[1], rs2);
      chk({tag, "_rd_b_warp"}, rd_warp[1], w);
    end
    for (int j = 0; j < bp; j++) begin
      check_outs($sformatf("%s_hold%0d", tag, j));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check_outs({tag, "_disp"});
    @(negedge clk);
    chk({tag, "_post_valid"}, bus.out_valid, 0);
    chk({tag, "_post_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    int seen;
    logic [4:0] rw, r1, r2;
    logic [31:0] rm;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_warp_id = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    bus.in_use_imm = 1'b0; bus.in_imm = '0; bus.in_alu_op = ALU_ADD; bus.in_active_mask = '0;
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        for (int i = 0; i < W; i++) rf_mem[a][b][i] = $urandom;
    for (int i = 0; i < W; i++) begin
      rf_mem[3][5][i] = 100 + i;
      rf_mem[3][7][i] = 2 * i;
    end

    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_txn("rr", 5'd3, 5'd5, 5'd7, 5'd12, 1'b0, 32'h0, ALU_SUB, 32'hFFFF_FFFF, 0);
    run_txn("imm", 5'd6, 5'd4, 5'd11, 5'd2, 1'b1, 32'hDEAD_BEEF, ALU_XOR, 32'hFFFF_FFFF, 0);
    run_txn("r0mask", 5'd9, 5'd0, 5'd9, 5'd1, 1'b0, 32'h0, ALU_AND, 32'h0000_FFFF, 0);
    run_txn("bp", 5'd3, 5'd7, 5'd5, 5'd30, 1'b0, 32'h0, ALU_SLT, 32'hA5A5_5A5A, 6);
    run_txn("empty", 5'd1, 5'd8, 5'd0, 5'd4, 1'b0, 32'h0, ALU_OR, 32'h0, 0);

    // flush during RD_B, then a fresh request
    drive_req(5'd2, 5'd10, 5'd11, 5'd3, 1'b0, 32'h0, ALU_ADD, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("flush_no_valid", seen, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    run_txn("after_flush", 5'd2, 5'd12, 5'd13, 5'd5, 1'b0, 32'h0, ALU_SRA, 32'hF0F0_F0F0, 0);

    // flush beats a same-cycle accept
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1 begin bus.in_valid = 1'b0; bus.flush = 1'b0; end
    @(negedge clk);
    chk("flush_accept_rd_en", bus.rf_rd_en, 0);
    chk("flush_accept_in_ready", bus.in_ready, 1);

    // flush beats the dispatch handshake
    bus.out_ready = 1'b1;
    drive_req(5'd4, 5'd14, 5'd0, 5'd6, 1'b1, 32'h1234_5678, ALU_SLL, 32'hFFFF_FFFF);
    seen = 0;
    for (int c = 0; c < 10 && !bus.out_valid; c++) @(negedge clk);
    chk("flush_disp_reached", bus.out_valid, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_disp_valid", bus.out_valid, 0);
    chk("flush_disp_in_ready", bus.in_ready, 1);

    // asynchronous reset in CAP_B
    drive_req(5'd3, 5'd5, 5'd7, 5'd8, 1'b0, 32'h0, ALU_MUL_FALLBACK(), 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("after_rst", 5'd3, 5'd7, 5'd5, 5'd9, 1'b0, 32'h0, ALU_ADD, 32'hFFFF_FFFF, 1);

    for (int t = 0; t < 25; t++) begin
      rw = 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r2 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 3))
        0:       rm = 32'hFFFF_FFFF;
        1:       rm = 32'h0;
        default: rm = $urandom;
      endcase
      run_txn($sformatf("rnd%0d", t), rw, r1, r2, 5'($urandom), 1'($urandom), $urandom,
              alu_op_t'($urandom_range(0, 9)), rm, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  function automatic alu_op_t ALU_MUL_FALLBACK();
    return ALU_SRL;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Upstream stage of the SIMD integer ALU.
- Accepts one issued warp instruction at a time and fetches its two source operands from the vector register file. The file has a single read port, returns a full warp per read, and has 1-cycle read latency.
- Assembles the per-lane operand vectors, then presents them with the ALU op and active mask to the execute stage over a valid/ready handshake.
- Handles register r0 (hardwired zero), immediate operand B, inactive-lane zeroing and pipeline flush.

Parameters:
- WARP_SIZE, 32, number of lanes per warp (package default).
- DATA_WIDTH, 32, bits per lane operand.
- REG_ADDR_WIDTH, 5, register index width (32 architectural registers).
- WARP_ID_WIDTH, 5, warp identifier width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort of any in-flight instruction.
- in_valid  input  1  issue request valid.
- in_ready  output  1  collector can accept a request.
- in_warp_id  input  WARP_ID_WIDTH  warp of the instruction.
- in_rs1  input  REG_ADDR_WIDTH  source A register.
- in_rs2  input  REG_ADDR_WIDTH  source B register.
- in_rd  input  REG_ADDR_WIDTH  destination register, passed through.
- in_use_imm  input  1  operand B is the immediate instead of rs2.
- in_imm  input  DATA_WIDTH  immediate, broadcast to all lanes.
- in_alu_op  input  alu_op_t  ALU operation, passed through.
- in_active_mask  input  WARP_SIZE  active lanes.
- rf_rd_en  output  1  register file read strobe.
- rf_rd_warp  output  WARP_ID_WIDTH  read warp.
- rf_rd_addr  output  REG_ADDR_WIDTH  read register.
- rf_rd_data  input  WARP_SIZE x DATA_WIDTH  read data, valid the cycle after rf_rd_en.
- out_valid  output  1  operands ready for the ALU.
- out_ready  input  1  ALU stage accepts.
- out_operand_a  output  WARP_SIZE x DATA_WIDTH  per-lane operand A.
- out_operand_b  output  WARP_SIZE x DATA_WIDTH  per-lane operand B.
- out_alu_op  output  alu_op_t  latched op.
- out_active_mask  output  WARP_SIZE  latched mask.
- out_warp_id  output  WARP_ID_WIDTH  latched warp.
- out_rd  output  REG_ADDR_WIDTH  latched destination.

Behaviour:
- FSM states: IDLE, RD_A, RD_B, CAP_B, DISPATCH.
- Reset (rst_n low, asynchronous): state IDLE.
  - in_ready=1, rf_rd_en=0, out_valid=0.
  - All out_* data, mask, warp, rd, rf_rd_warp and rf_rd_addr = 0; out_alu_op = enum value 0.
- IDLE: in_ready=1. On in_valid & in_ready at edge k:
  - latch all in_* fields;
  - go to RD_A.
- RD_A (cycle k+1): rf_rd_en=1, rf_rd_addr=rs1, rf_rd_warp=warp. Go to RD_B.
- RD_B (cycle k+2):
  - Capture rf_rd_data as operand A at the closing edge.
  - If !use_imm: rf_rd_en=1, rf_rd_addr=rs2, go to CAP_B.
  - If use_imm: rf_rd_en=0, operand B = imm in every lane, go to DISPATCH.
- CAP_B (cycle k+3): capture rf_rd_data as operand B. Go to DISPATCH.
- DISPATCH: out_valid=1.
  - All out_* stay stable until out_valid & out_ready.
  - After that handshake go to IDLE; out_valid drops the next cycle.
- Latency from accept edge to first out_valid cycle:
  - 4 cycles for register-register (k+4);
  - 3 cycles for immediate (k+3).
- Back-to-back throughput: one instruction per 5 cycles (register-register) or 4 cycles (immediate) with out_ready held high.
- in_ready=0 in every state except IDLE.
- r0 handling:
  - if rs1==0, operand A = 0 in all lanes;
  - if rs2==0 and !use_imm, operand B = 0 in all lanes;
  - the read is still issued so the timing is identical.
- Inactive lanes (mask bit 0): both operands forced to 0 for that lane.
- Active-lane data is passed unmodified; no width change.
- Empty mask (all 0) is still dispatched normally, with all operands 0.
- flush:
  - In any state, at the next edge: go to IDLE, out_valid=0, rf_rd_en=0. Latched data values are don't-care.
  - A read response arriving after a flush is ignored.
  - flush has priority over a same-cycle in_valid accept (request not accepted) and over a DISPATCH handshake (instruction dropped; the bench must not count it).
- Reset asserted mid-operation: immediate return to the reset state, with the same values as above.

Test Plan:
- Register-register: warp 3, rs1=5, rs2=7, mask all 1s, RF model returns lane i = 100+i for r5 and 2*i for r7.
  -> rf_rd_addr 5 at k+1, then 7 at k+2; out_valid at k+4 with operand_a[i]=100+i and operand_b[i]=2*i; warp, rd, op and mask echoed.
- Immediate: rs1=4, use_imm=1, imm=0xDEADBEEF.
  -> exactly one rf_rd_en pulse; out_valid at k+3; all lanes operand_b=0xDEADBEEF.
- r0 and mask: rs1=0, rs2=9, mask=0x0000FFFF.
  -> operand_a all 0; operand_b lanes 0-15 carry RF data, lanes 16-31 are 0.
- Backpressure: out_ready held low 6 cycles in DISPATCH.
  -> out_valid and all outputs stable, in_ready=0; handshake on the first out_ready cycle, then IDLE.
- Flush: assert flush during RD_B, then a second request arrives.
  -> no out_valid for the first request; second request gives correct operands with nominal latency.
- Async reset during CAP_B.
  -> outputs go to reset values without a clock edge; after release, a new request completes correctly.
